alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Multi-cycle integer ALU; the consumer of the 4-bit alu_ctrl code produced by the ALU control decoder.
//  Accepts {alu_ctrl, op_a, op_b} over a valid/ready handshake and returns a registered result plus zero flag.
//  Non-shift ops: 1 cycle. Shifts: iterative, SHIFT_STEP bits/cycle.
//  Sits in EX stage; zero_o feeds BEQ/BNE, result_o[0] feeds BLT/BGE.
// PARAMETERS
//  XLEN        32  operand/result width; power of 2; shamt width SW = log2(XLEN)
//  SHIFT_STEP  1   max bit positions shifted per cycle; legal 1,2,4,8
// PORTS
//  clk_i       in   1     clock, rising edge
//  rst_i       in   1     asynchronous, active-high reset
//  flush_i     in   1     synchronous abort of any op in flight
//  valid_i     in   1     request valid
//  ready_o     out  1     unit can accept request (state IDLE and !rst_i)
//  alu_ctrl_i  in   4     op: 0000 ADD,0001 AND,0010 OR,0011 XOR,0100 SLL,0101 SRL,0110 SRA,0111 SUB,1000 SLTU,1001 SLT
//  op_a_i      in   XLEN  operand A
//  op_b_i      in   XLEN  operand B; shifts use op_b_i[SW-1:0] only
//  valid_o     out  1     result valid (state DONE)
//  ready_i     in   1     downstream accepts result
//  result_o    out  XLEN  registered result, stable while valid_o && !ready_i
//  zero_o      out  1     registered (result == 0), updated with result_o
//  busy_o      out  1     state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, valid_o=0, result_o=0, zero_o=0, busy_o=0, ready_o=0 while rst_i high, 1 after.
//  FSM IDLE/SHIFT/DONE; request accepted in cycle T when valid_i && ready_o; operands captured.
//  IDLE: on accept of non-shift op, or shift with shamt==0 -> result registered, DONE at T+1.
//    On accept of shift with shamt!=0 -> acc=op_a, cnt=shamt, kind latched -> SHIFT.
//  SHIFT: each cycle shift acc by n=min(cnt,SHIFT_STEP), cnt-=n; when cnt<=SHIFT_STEP, final step goes to DONE.
//    valid_o rises at T+1+ceil(shamt/SHIFT_STEP). SRA fills with acc sign bit captured at accept.
//  DONE: valid_o=1; result_o/zero_o held; valid_o && ready_i -> IDLE next cycle (no same-cycle re-accept).
//  Arithmetic: ADD/SUB modulo 2^XLEN, carry discarded. SLT signed compare, SLTU unsigned; result 0 or 1 zero-extended.
//  Codes 1010-1111: executed as ADD (matches decoder default).
//  flush_i: from any state -> IDLE next cycle, valid_o=0, result_o/zero_o unchanged;
//    flush_i has priority over accept and over ready_i; a flush in the accept cycle drops the request.
//  rst_i asserted mid-operation: all outputs to reset values immediately; op discarded.
//  Inputs ignored whenever ready_o=0; alu_ctrl_i/op_*_i need only be stable in the accept cycle.
// TESTING
//  SUB a=5 b=7 accepted at T -> valid_o at T+1, result_o=0xFFFFFFFE, zero_o=0; SUB 9,9 -> 0, zero_o=1.
//  SLL a=1 b=31, SHIFT_STEP=1 -> ready_o=0, busy_o=1 T+1..T+32, valid_o at T+32, result 0x80000000.
//  SRA a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000 at T+5; SRL same -> 0x08000000; STEP=4 -> at T+2.
//  SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0; code 1111 a=2 b=3 -> 5; SLL b=0 -> a at T+1.
//  DONE with ready_i low 3 cycles -> result_o/valid_o held; ready_i high -> IDLE, ready_o=1 next cycle.
//  flush_i at T+3 of 31-bit shift -> IDLE at T+4, valid_o never asserted; rst_i mid-shift -> all outputs 0 at once.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Summary  : Multi-cycle integer ALU with valid/ready handshake and iterative shifter.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            busy_o
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [1:0] K_SLL = 2'b00;
    localparam logic [1:0] K_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] acc, acc_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [1:0]      kind, kind_nx;
    logic            sign, sign_nx;
    logic [XLEN-1:0] result_nx;
    logic            zero_nx;

    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic [CW-1:0]   step_n;
    logic [XLEN-1:0] fill;
    logic [XLEN-1:0] shifted;

    assign shamt    = op_b_i[SW-1:0];
    assign is_shift = (alu_ctrl_i == 4'b0100) || (alu_ctrl_i == 4'b0101) ||
                      (alu_ctrl_i == 4'b0110);
    assign ready_o  = (state == IDLE) && !rst_i;
    assign accept   = valid_i && ready_o && !flush_i;
    assign valid_o  = (state == DONE);
    assign busy_o   = (state != IDLE);

    // Single-cycle datapath; shifts only reach here with a zero shift amount.
    always_comb begin
        alu_res = op_a_i + op_b_i;
        case (alu_ctrl_i)
            4'b0001: alu_res = op_a_i & op_b_i;
            4'b0010: alu_res = op_a_i | op_b_i;
            4'b0011: alu_res = op_a_i ^ op_b_i;
            4'b0100,
            4'b0101,
            4'b0110: alu_res = op_a_i;
            4'b0111: alu_res = op_a_i - op_b_i;
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            default: alu_res = op_a_i + op_b_i;
        endcase
    end

    // One shifter step of min(cnt, STEP) positions; SRA fills with the latched sign.
    always_comb begin
        step_n  = (cnt < STEP) ? cnt : STEP;
        fill    = sign ? ~({XLEN{1'b1}} >> step_n) : '0;
        shifted = acc >> step_n;
        if (kind == K_SLL) begin
            shifted = acc << step_n;
        end else if (kind == K_SRA) begin
            shifted = (acc >> step_n) | fill;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        kind_nx   = kind;
        sign_nx   = sign;
        result_nx = result_o;
        zero_nx   = zero_o;
        if (flush_i) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            acc_nx   = op_a_i;
                            cnt_nx   = {1'b0, shamt};
                            kind_nx  = alu_ctrl_i[1:0];
                            sign_nx  = op_a_i[XLEN-1];
                            state_nx = SHIFT;
                        end else begin
                            result_nx = alu_res;
                            zero_nx   = (alu_res == '0);
                            state_nx  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc_nx = shifted;
                    cnt_nx = cnt - step_n;
                    if (cnt <= STEP) begin
                        result_nx = shifted;
                        zero_nx   = (shifted == '0);
                        state_nx  = DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            kind     <= '0;
            sign     <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            kind     <= kind_nx;
            sign     <= sign_nx;
            result_o <= result_nx;
            zero_o   <= zero_nx;
        end
    end

endmodule
`default_nettype wire
